// File: rtl/uart_8250_tx_sequencer.sv
// Wishbone classic master for a uart_8250: runs the DLAB programming sequence on
// request, then streams bytes into THR, polling LSR.THRE before every write.
module uart_8250_tx_sequencer #(
  parameter logic [31:0] BASE_ADDR   = 32'h1250_0000,
  parameter int          ACK_TIMEOUT = 64,
  parameter int          POLL_GAP    = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic        STB_O,
  input  logic        ACK_I,
  output logic        CYC_O,
  input  logic        cfg_start,
  input  logic [15:0] cfg_divisor,
  input  logic [7:0]  cfg_lcr,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        cfg_done,
  output logic        busy,
  output logic        bus_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_C_LCR_DLAB = 4'd1;
  localparam logic [3:0] S_C_DLL      = 4'd2;
  localparam logic [3:0] S_C_DLM      = 4'd3;
  localparam logic [3:0] S_C_LCR      = 4'd4;
  localparam logic [3:0] S_C_IER      = 4'd5;
  localparam logic [3:0] S_READY      = 4'd6;
  localparam logic [3:0] S_POLL_LSR   = 4'd7;
  localparam logic [3:0] S_POLL_WAIT  = 4'd8;
  localparam logic [3:0] S_W_THR      = 4'd9;
  localparam logic [3:0] S_ERROR      = 4'd10;

  typedef struct packed {
    logic [2:0] ofs;
    logic [7:0] dat;
    logic       we;
  } bus_req_t;

  logic [3:0]    state_q, state_d;
  logic          cyc_q, cyc_d, we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic [15:0]   div_q, div_d;
  logic [7:0]    lcr_q, lcr_d, byte_q, byte_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          cfg_done_q, cfg_done_d, bus_err_q, bus_err_d;
  logic          launch, cfg_go;
  bus_req_t      req;

  assign cfg_go = cfg_start && (state_q inside {S_IDLE, S_READY, S_ERROR});

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    div_d      = div_q;
    lcr_d      = lcr_q;
    byte_d     = byte_q;
    to_cnt_d   = to_cnt_q;
    gap_d      = gap_q;
    cfg_done_d = cfg_done_q;
    bus_err_d  = bus_err_q;
    launch     = 1'b0;
    req        = '0;

    if (cfg_go) begin
      div_d      = cfg_divisor;
      lcr_d      = cfg_lcr;
      bus_err_d  = 1'b0;
      cfg_done_d = 1'b0;
      state_d    = S_C_LCR_DLAB;
      launch     = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: ;
        S_READY: begin
          if (tx_valid) begin
            byte_d  = tx_data;
            state_d = S_POLL_LSR;
            launch  = 1'b1;
          end
        end
        S_POLL_WAIT: begin
          if (gap_q == GAP_LAST) begin
            state_d = S_POLL_LSR;
            launch  = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_C_LCR_DLAB, S_C_DLL, S_C_DLM, S_C_LCR, S_C_IER, S_POLL_LSR, S_W_THR: begin
          // cyc_q low here means the mandatory idle cycle after the previous ACK
          if (!cyc_q) begin
            launch = 1'b1;
          end else if (ACK_I) begin
            cyc_d = 1'b0;
            sel_d = 4'b0000;
            case (state_q)
              S_C_LCR_DLAB: state_d = S_C_DLL;
              S_C_DLL:      state_d = S_C_DLM;
              S_C_DLM:      state_d = S_C_LCR;
              S_C_LCR:      state_d = S_C_IER;
              S_C_IER: begin
                state_d    = S_READY;
                cfg_done_d = 1'b1;
              end
              S_POLL_LSR: begin
                if (DAT_I[5]) begin
                  state_d = S_W_THR;
                end else begin
                  state_d = S_POLL_WAIT;
                  gap_d   = '0;
                end
              end
              default:      state_d = S_READY;
            endcase
          end else if (to_cnt_q == TO_LAST) begin
            cyc_d      = 1'b0;
            sel_d      = 4'b0000;
            state_d    = S_ERROR;
            bus_err_d  = 1'b1;
            cfg_done_d = 1'b0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Bus request is built from the next-state view so a cycle can start on entry
    if (launch) begin
      case (state_d)
        S_C_LCR_DLAB: req = '{ofs: 3'd3, dat: 8'h80,                 we: 1'b1};
        S_C_DLL:      req = '{ofs: 3'd0, dat: div_d[7:0],            we: 1'b1};
        S_C_DLM:      req = '{ofs: 3'd1, dat: div_d[15:8],           we: 1'b1};
        S_C_LCR:      req = '{ofs: 3'd3, dat: lcr_d & 8'h7F,         we: 1'b1};
        S_C_IER:      req = '{ofs: 3'd1, dat: 8'h00,                 we: 1'b1};
        S_POLL_LSR:   req = '{ofs: 3'd5, dat: 8'h00,                 we: 1'b0};
        default:      req = '{ofs: 3'd0, dat: byte_d,                we: 1'b1};
      endcase
      cyc_d    = 1'b1;
      sel_d    = 4'b0001;
      to_cnt_d = '0;
      adr_d    = BASE_ADDR + {29'd0, req.ofs};
      dat_d    = req.dat;
      we_d     = req.we;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'b0000;
      adr_q      <= '0;
      dat_q      <= '0;
      div_q      <= '0;
      lcr_q      <= '0;
      byte_q     <= '0;
      to_cnt_q   <= '0;
      gap_q      <= '0;
      cfg_done_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      div_q      <= div_d;
      lcr_q      <= lcr_d;
      byte_q     <= byte_d;
      to_cnt_q   <= to_cnt_d;
      gap_q      <= gap_d;
      cfg_done_q <= cfg_done_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign CYC_O    = cyc_q;
  assign STB_O    = cyc_q;
  assign ADR_O    = adr_q;
  assign DAT_O    = {24'd0, dat_q};
  assign WE_O     = we_q;
  assign SEL_O    = sel_q;
  assign tx_ready = (state_q == S_READY) && !cfg_start;
  assign cfg_done = cfg_done_q;
  assign bus_err  = bus_err_q;
  assign busy     = !(state_q inside {S_IDLE, S_READY, S_ERROR});

  // Only THRE matters; the rest of the read word is don't-care
  logic unused_dat;
  assign unused_dat = ^{DAT_I[31:6], DAT_I[4:0]};

endmodule

// File: tb/tb_uart_8250_tx_sequencer.sv
// Bench for uart_8250_tx_sequencer: directed stimulus pushes expected bus
// transactions; a negedge monitor pops and compares each completed Wishbone cycle.
module tb_uart_8250_tx_sequencer;
  localparam logic [31:0] BASE = 32'h1250_0000;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] ADR_O, DAT_O;
  logic [31:0] DAT_I = '0;
  logic        WE_O, STB_O, CYC_O;
  logic [3:0]  SEL_O;
  logic        ACK_I;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_divisor = '0;
  logic [7:0]  cfg_lcr = '0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, cfg_done, busy, bus_err;

  uart_8250_tx_sequencer dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
    .WE_O(WE_O), .SEL_O(SEL_O), .STB_O(STB_O), .ACK_I(ACK_I), .CYC_O(CYC_O),
    .cfg_start(cfg_start), .cfg_divisor(cfg_divisor), .cfg_lcr(cfg_lcr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_done(cfg_done), .busy(busy), .bus_err(bus_err)
  );

  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  int         ack_delay = 0;
  bit         hang = 1'b0;
  bit         stray_ack = 1'b0;
  logic       ack_r;
  int         wcnt;
  logic [7:0] lsr_q[$];

  assign ACK_I = ack_r | stray_ack;

  function automatic logic [7:0] lsr_next();
    if (lsr_q.size() == 0) return 8'h20;
    return lsr_q.pop_front();
  endfunction

  always @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ack_r <= 1'b0;
      wcnt  <= 0;
    end else if (!CYC_O || ack_r) begin
      ack_r <= 1'b0;
      wcnt  <= 0;
    end else if (hang && WE_O && ADR_O == BASE) begin
      wcnt <= wcnt + 1;
    end else if (wcnt >= ack_delay) begin
      ack_r <= 1'b1;
      if (!WE_O) DAT_I <= {24'hA5C3F0, lsr_next()};
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] adr;
    logic [7:0]  dat;
    logic        we;
    int          len;    // cycles CYC_O high, 0 = don't care
    int          gap;    // idle cycles before start, 0 = don't care
    logic        abort;
  } exp_t;
  exp_t exp_q[$];

  task automatic exp_push(input logic [31:0] adr, input logic [7:0] dat, input logic we,
                          input int len, input int gap, input logic abort);
    exp_t e;
    e.adr = adr; e.dat = dat; e.we = we; e.len = len; e.gap = gap; e.abort = abort;
    exp_q.push_back(e);
  endtask

  task automatic exp_cfg(input logic [7:0] dll, input logic [7:0] dlm, input logic [7:0] lcr,
                         input int len);
    exp_push(BASE + 3, 8'h80, 1'b1, len, 0, 1'b0);
    exp_push(BASE + 0, dll,   1'b1, len, 0, 1'b0);
    exp_push(BASE + 1, dlm,   1'b1, len, 0, 1'b0);
    exp_push(BASE + 3, lcr,   1'b1, len, 0, 1'b0);
    exp_push(BASE + 1, 8'h00, 1'b1, len, 0, 1'b0);
  endtask

  bit          in_cyc = 1'b0, ack_seen = 1'b0, stable = 1'b1;
  int          hold = 0, idle = 100;
  logic [31:0] c_adr, c_dat;
  logic        c_we;
  logic [3:0]  c_sel;

  task automatic complete(input logic aborted);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_txn: got adr=%h dat=%h we=%0d expected none", c_adr, c_dat, c_we);
      return;
    end
    e = exp_q.pop_front();
    chk("txn_adr", c_adr, e.adr);
    chk("txn_dat", c_dat, {24'd0, e.dat});
    chk("txn_we", {31'd0, c_we}, {31'd0, e.we});
    chk("txn_sel", {28'd0, c_sel}, 32'h1);
    chk("txn_abort", {31'd0, aborted}, {31'd0, e.abort});
    chk("txn_stable", {31'd0, stable}, 32'h1);
    if (e.len != 0) chk("txn_len", hold, e.len);
  endtask

  always @(negedge CLK_I) begin
    if (!RST_I) begin
      if (in_cyc) complete(1'b1);
      in_cyc = 1'b0; ack_seen = 1'b0; idle = 100;
    end else begin
      if (ack_seen) chk("idle_after_ack", {31'd0, CYC_O}, 32'h0);
      ack_seen = 1'b0;
      if (CYC_O) begin
        if (!in_cyc) begin
          if (exp_q.size() != 0 && exp_q[0].gap != 0) chk("poll_gap", idle, exp_q[0].gap);
          chk("stb_with_cyc", {31'd0, STB_O}, 32'h1);
          in_cyc = 1'b1; stable = 1'b1; hold = 1;
          c_adr = ADR_O; c_dat = DAT_O; c_we = WE_O; c_sel = SEL_O;
        end else begin
          hold++;
          if (ADR_O !== c_adr || DAT_O !== c_dat || WE_O !== c_we || SEL_O !== c_sel || STB_O !== 1'b1)
            stable = 1'b0;
        end
        if (ACK_I) begin
          complete(1'b0);
          in_cyc = 1'b0; ack_seen = 1'b1; idle = 0;
        end
      end else begin
        if (in_cyc) complete(1'b1);
        in_cyc = 1'b0;
        idle++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cfg(input logic [15:0] div, input logic [7:0] lcr,
                        input logic with_tx, input logic expect_err);
    int n;
    @(negedge CLK_I);
    cfg_divisor = div; cfg_lcr = lcr; cfg_start = 1'b1;
    if (with_tx) begin tx_valid = 1'b1; tx_data = 8'h99; end
    #1 chk("tx_ready_cfg_prio", {31'd0, tx_ready}, 32'h0);
    @(negedge CLK_I);
    cfg_start = 1'b0; tx_valid = 1'b0;
    chk("busy_in_cfg", {31'd0, busy}, 32'h1);
    chk("bus_err_cleared", {31'd0, bus_err}, 32'h0);
    chk("cfg_done_cleared", {31'd0, cfg_done}, 32'h0);
    n = 0;
    while (!cfg_done && !bus_err && n < 400) begin @(negedge CLK_I); n++; end
    if (expect_err) begin
      chk("err_bus_err", {31'd0, bus_err}, 32'h1);
      chk("err_cfg_done", {31'd0, cfg_done}, 32'h0);
      chk("err_tx_ready", {31'd0, tx_ready}, 32'h0);
      chk("err_cyc", {31'd0, CYC_O}, 32'h0);
    end else begin
      chk("cfg_done", {31'd0, cfg_done}, 32'h1);
      chk("busy_after_cfg", {31'd0, busy}, 32'h0);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    tx_data = b; tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 300) begin @(negedge CLK_I); n++; end
    chk("tx_ready_seen", {31'd0, tx_ready}, 32'h1);
    @(negedge CLK_I);
    tx_valid = 1'b0;
    chk("tx_ready_low_after_hs", {31'd0, tx_ready}, 32'h0);
    chk("busy_in_tx", {31'd0, busy}, 32'h1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!tx_ready && n < 300) begin @(negedge CLK_I); n++; end
    chk("back_to_ready", {31'd0, tx_ready}, 32'h1);
    chk("busy_idle", {31'd0, busy}, 32'h0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge CLK_I);
    chk("rst_adr", ADR_O, 32'h0);
    chk("rst_dat", DAT_O, 32'h0);
    chk("rst_ctl", {26'd0, WE_O, SEL_O, STB_O}, 32'h0);
    chk("rst_cyc", {31'd0, CYC_O}, 32'h0);
    chk("rst_status", {28'd0, tx_ready, cfg_done, busy, bus_err}, 32'h0);
    RST_I = 1'b1;

    // tx_valid in IDLE is not accepted
    @(negedge CLK_I); tx_valid = 1'b1; tx_data = 8'hEE;
    #1 chk("idle_tx_ready", {31'd0, tx_ready}, 32'h0);
    @(negedge CLK_I); tx_valid = 1'b0;
    chk("idle_no_cyc", {31'd0, CYC_O}, 32'h0);

    // Basic config, slave ACKs next cycle
    exp_cfg(8'h03, 8'h00, 8'h03, 2);
    do_cfg(16'h0003, 8'h83, 1'b0, 1'b0);

    // ACK while idle is ignored
    @(negedge CLK_I); stray_ack = 1'b1;
    @(negedge CLK_I); stray_ack = 1'b0;
    chk("stray_ack_no_cyc", {31'd0, CYC_O}, 32'h0);
    chk("stray_ack_ready", {31'd0, tx_ready}, 32'h1);

    // Back-to-back transmit, THRE set on first read
    lsr_q.push_back(8'h60); lsr_q.push_back(8'h60); lsr_q.push_back(8'h60);
    exp_push(BASE + 5, 8'h00, 1'b0, 2, 0, 1'b0); exp_push(BASE + 0, 8'h12, 1'b1, 2, 0, 1'b0);
    exp_push(BASE + 5, 8'h00, 1'b0, 2, 0, 1'b0); exp_push(BASE + 0, 8'h34, 1'b1, 2, 0, 1'b0);
    exp_push(BASE + 5, 8'h00, 1'b0, 2, 0, 1'b0); exp_push(BASE + 0, 8'h56, 1'b1, 2, 0, 1'b0);
    @(negedge CLK_I);
    send(8'h12); send(8'h34); send(8'h56);
    wait_ready();

    // Polling with THRE clear twice; cfg_start while busy is ignored
    lsr_q.push_back(8'h00); lsr_q.push_back(8'h00); lsr_q.push_back(8'h20);
    exp_push(BASE + 5, 8'h00, 1'b0, 2, 0, 1'b0);
    exp_push(BASE + 5, 8'h00, 1'b0, 2, 4, 1'b0);
    exp_push(BASE + 5, 8'h00, 1'b0, 2, 4, 1'b0);
    exp_push(BASE + 0, 8'h77, 1'b1, 2, 0, 1'b0);
    @(negedge CLK_I);
    send(8'h77);
    cfg_start = 1'b1;
    @(negedge CLK_I); cfg_start = 1'b0;
    wait_ready();
    chk("cfg_done_kept", {31'd0, cfg_done}, 32'h1);

    // Wait states: CYC_O held 11 cycles; cfg_start beats tx_valid
    ack_delay = 9;
    exp_cfg(8'h00, 8'h01, 8'h1B, 11);
    do_cfg(16'h0100, 8'h1B, 1'b1, 1'b0);
    ack_delay = 0;

    // Timeout on the DLL write
    hang = 1'b1;
    exp_push(BASE + 3, 8'h80, 1'b1, 2, 0, 1'b0);
    exp_push(BASE + 0, 8'h34, 1'b1, 64, 0, 1'b1);
    do_cfg(16'h1234, 8'hFF, 1'b0, 1'b1);
    hang = 1'b0;
    @(negedge CLK_I); tx_valid = 1'b1; tx_data = 8'hAB;
    #1 chk("error_tx_ready", {31'd0, tx_ready}, 32'h0);
    @(negedge CLK_I); tx_valid = 1'b0;
    chk("error_no_cyc", {31'd0, CYC_O}, 32'h0);
    chk("error_sticky", {31'd0, bus_err}, 32'h1);

    // Recovery from ERROR
    exp_cfg(8'h0B, 8'h0A, 8'h7F, 2);
    do_cfg(16'h0A0B, 8'hFF, 1'b0, 1'b0);

    // Reset in the middle of a THR write
    ack_delay = 20;
    lsr_q.push_back(8'h20);
    exp_push(BASE + 5, 8'h00, 1'b0, 22, 0, 1'b0);
    exp_push(BASE + 0, 8'hC4, 1'b1, 0, 0, 1'b1);
    @(negedge CLK_I);
    send(8'hC4);
    n = 0;
    while (!(CYC_O && WE_O) && n < 200) begin @(negedge CLK_I); n++; end
    chk("thr_cycle_seen", {30'd0, CYC_O, WE_O}, 32'h3);
    #2 RST_I = 1'b0;
    #1 chk("async_rst_cyc_stb", {30'd0, CYC_O, STB_O}, 32'h0);
    chk("async_rst_adr", ADR_O, 32'h0);
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    ack_delay = 0;
    @(negedge CLK_I);
    chk("post_rst_status", {28'd0, tx_ready, cfg_done, busy, bus_err}, 32'h0);
    chk("post_rst_cyc", {31'd0, CYC_O}, 32'h0);

    repeat (4) @(negedge CLK_I);
    chk("exp_queue_empty", exp_q.size(), 32'h0);
    chk("lsr_queue_empty", lsr_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_8250_tx_sequencer.md
Name: uart_8250_tx_sequencer

Overview:
Wishbone classic master that owns the uart_8250 register port and sequences it.
- On request, programs the baud divisor, line control and interrupt enable through the DLAB sequence.
- Then feeds bytes from a valid/ready stream into THR, polling LSR.THRE before each write.
- Sits between firmware-free logic (boot console, debug streamer) and the uart_8250 slave.

Parameters:
BASE_ADDR, 32'h1250_0000, UART register base; register offset added to it (byte offsets: THR/DLL 0, IER/DLM 1, LCR 3, LSR 5)
ACK_TIMEOUT, 64, cycles a bus cycle may wait for ACK_I before abort
POLL_GAP, 4, idle cycles between successive LSR reads while THRE=0

Ports:
CLK_I  in  1  system clock, all logic on rising edge
RST_I  in  1  asynchronous, active-low reset
ADR_O  out 32  Wishbone address
DAT_O  out 32  write data, byte in [7:0], [31:8]=0
DAT_I  in  32  read data, register byte in [7:0]
WE_O   out 1  write enable
SEL_O  out 4  byte select, always 4'b0001 during a cycle
STB_O  out 1  strobe
ACK_I  in  1  slave acknowledge
CYC_O  out 1  bus cycle
cfg_start   in  1  pulse: (re)run configuration sequence
cfg_divisor in  16  baud divisor {DLM,DLL}
cfg_lcr     in  8  line control; bit7 forced 0 when written
tx_data     in  8  byte to send
tx_valid    in  1  tx_data valid
tx_ready    out 1  sequencer accepts byte this cycle
cfg_done    out 1  configuration complete, UART usable
busy        out 1  config or transmit in progress
bus_err     out 1  sticky: ACK timeout occurred

Behaviour:
Reset (RST_I=0, async):
- ADR_O=0, DAT_O=0, WE_O=0, SEL_O=0, STB_O=0, CYC_O=0, tx_ready=0, cfg_done=0, busy=0, bus_err=0; state IDLE.
- Reset mid-transaction drops CYC_O/STB_O immediately, without waiting for a clock.

States: IDLE, C_LCR_DLAB, C_DLL, C_DLM, C_LCR, C_IER, READY, POLL_LSR, POLL_WAIT, W_THR, ERROR.

Bus cycle (every C_*, POLL_LSR, W_THR state):
- First cycle in state: CYC_O=STB_O=1, ADR_O/DAT_O/WE_O/SEL_O driven.
- All held stable until ACK_I=1 sampled at a rising edge.
- Next cycle CYC_O=STB_O=0; at least one idle cycle between consecutive bus cycles.
- Read data sampled on the ACK edge.
- ACK_I while CYC_O=0 is ignored.

Timeout:
- Counter clears at cycle start.
- ACK_TIMEOUT cycles without ACK -> drop CYC_O/STB_O, bus_err=1, cfg_done=0, state ERROR.

Config sequence (cfg_start in IDLE, READY or ERROR; busy=1 throughout). Writes in order:
- LCR<=0x80
- DLL<=cfg_divisor[7:0]
- DLM<=cfg_divisor[15:8]
- LCR<=cfg_lcr&0x7F
- IER<=0x00

Inputs are latched on cfg_start. Completion -> cfg_done=1, state READY. cfg_start clears bus_err and cfg_done.

READY:
- tx_ready=1 iff state READY and cfg_start=0; cfg_start has priority over tx_valid in the same cycle.
- Handshake tx_valid&tx_ready latches tx_data, busy=1, state POLL_LSR.
- tx_ready is low in all other states.

POLL_LSR:
- Read BASE+5.
- DAT_I[5]=1 -> W_THR.
- Else POLL_WAIT for POLL_GAP cycles, then POLL_LSR again. Polling is unbounded; only a timeout or reset aborts it.

W_THR:
- Write latched byte to BASE+0.
- On ACK -> READY, busy=0.
- Best-case byte latency: handshake to THR ACK = 5 cycles with zero-wait ACK.

cfg_start outside IDLE/READY/ERROR is ignored.
tx_valid in IDLE/ERROR is not accepted (tx_ready=0).

Test Plan:
- Config: reset, cfg_divisor=16'h0003, cfg_lcr=8'h83, cfg_start; slave ACKs next cycle -> writes (1250_0003,80),(1250_0000,03),(1250_0001,00),(1250_0003,03),(1250_0001,00) in order, SEL_O=0001, idle cycle between each, then cfg_done=1, busy=0.
- Transmit: after config, send 8'h12, 8'h34, 8'h56 back-to-back, LSR reads return 0x60 -> each byte is one LSR read then one THR write of that byte; tx_ready low between handshakes.
- Poll: LSR returns 0x00 twice then 0x20 -> three LSR reads spaced by POLL_GAP=4 idle cycles, then THR write.
- Wait states: slave delays ACK by 10 cycles -> ADR_O/DAT_O/WE_O/STB_O held constant for all 11 cycles; sequence completes normally.
- Timeout: slave never ACKs DLL write -> after 64 cycles CYC_O=0, bus_err=1, cfg_done=0, tx_ready=0; a later cfg_start clears bus_err and reruns the full sequence.
- Reset mid-cycle: assert RST_I=0 during a THR write with CYC_O=1 -> CYC_O/STB_O fall without a clock edge; after release, state IDLE, cfg_done=0.
